// File: rtl/sti_pkg.sv
// sti_pkg: shared types and 3-share component functions for the threshold PRESENT S-box (S = G o F, both quadratic)
package sti_pkg;
  localparam int SBOX_W = 4;
  localparam int SHARES = 3;
  typedef logic [SBOX_W-1:0] sbox_t;
  typedef enum logic {STAGE_F, STAGE_G} stage_e;
  localparam logic [63:0] PRESENT_TT = 64'h2174_8FE3_DA09_B65C;
  function automatic logic q(sbox_t a, sbox_t b, int u, int v);
    return (a[u] & a[v]) ^ (a[u] & b[v]) ^ (b[u] & a[v]);
  endfunction
  // output share i sees only shares i+1 (a) and i+2 (b); c carries the affine constant on share 0
  function automatic sbox_t f_comp(sbox_t a, sbox_t b, logic c);
    return {a[2] ^ a[1] ^ a[0],
            c ^ a[2] ^ a[1],
            c ^ a[3] ^ a[1] ^ q(a, b, 2, 0) ^ q(a, b, 1, 0),
            c ^ a[0] ^ q(a, b, 3, 2) ^ q(a, b, 3, 1) ^ q(a, b, 2, 1)};
  endfunction
  function automatic sbox_t g_comp(sbox_t a, sbox_t b);
    return {a[2] ^ a[1] ^ a[0] ^ q(a, b, 3, 0),
            a[3] ^ q(a, b, 1, 0),
            a[2] ^ a[1] ^ q(a, b, 3, 0),
            a[1] ^ q(a, b, 2, 0)};
  endfunction
endpackage

// File: rtl/sti_lane_stage.sv
// sti_lane_stage: non-complete 3-share combinational component layer (F or G) for one nibble lane
module sti_lane_stage
  import sti_pkg::*;
#(
  parameter stage_e SEL = STAGE_F
) (
  input  logic [SHARES*SBOX_W-1:0] sh,
  output logic [SHARES*SBOX_W-1:0] o
);
  for (genvar s = 0; s < SHARES; s++) begin : g_sh
    localparam int A = SBOX_W * ((s + 1) % SHARES);
    localparam int B = SBOX_W * ((s + 2) % SHARES);
    assign o[SBOX_W*s +: SBOX_W] = SEL == STAGE_F ? f_comp(sh[A +: SBOX_W], sh[B +: SBOX_W], 1'(s == 0))
                                                  : g_comp(sh[A +: SBOX_W], sh[B +: SBOX_W]);
  end
endmodule

// File: rtl/sti_sbox_pipe.sv
// sti_sbox_pipe: two-stage threshold PRESENT S-box over LANES nibbles with remasked F/G boundary register
module sti_sbox_pipe
  import sti_pkg::*;
#(
  parameter int LANES  = 16,
  parameter bit REMASK = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [12*LANES-1:0] in_sh,
  input  logic [8*LANES-1:0]  rnd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [12*LANES-1:0] out_sh,
  output logic               busy
);
  logic v1, v2, adv1, adv2;
  logic [12*LANES-1:0] reg1, reg2, f_out, g_out, mask;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sti_lane_stage #(.SEL(STAGE_F)) u_f (.sh(in_sh[12*l +: 12]), .o(f_out[12*l +: 12]));
    sti_lane_stage #(.SEL(STAGE_G)) u_g (.sh(reg1[12*l +: 12]), .o(g_out[12*l +: 12]));
    assign mask[12*l +: 12] = REMASK ? {rnd[8*l+4 +: 4], rnd[8*l+4 +: 4] ^ rnd[8*l +: 4], rnd[8*l +: 4]} : 12'h0;
  end
  assign adv2      = v1 & (~v2 | out_ready);
  assign in_ready  = ~v1 | adv2;
  assign adv1      = in_valid & in_ready;
  assign out_valid = v2;
  assign out_sh    = reg2;
  assign busy      = v1 | v2;
  // data registers move only on their advance strobe so idle cycles never mix shares
  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      reg1 <= '0;
      reg2 <= '0;
    end else begin
      v1 <= adv1 | (v1 & ~adv2);
      v2 <= adv2 | (v2 & ~out_ready);
      if (adv1) reg1 <= f_out ^ mask;
      if (adv2) reg2 <= g_out;
    end
  end
endmodule

// File: tb/tb_sti_sbox_pipe.sv
// tb_sti_sbox_pipe: directed and randomized checks of the threshold S-box pipe against an unmasked PRESENT model
module tb_sti_sbox_pipe;
  localparam int L = 16;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic [12*L-1:0] in_sh = '0, out_sh;
  logic [8*L-1:0] rnd = '0;
  int checks = 0, errors = 0, cyc = 0;
  logic acc, emit, lat_chk = 1'b0;
  logic [12*L-1:0] last_out;
  logic [4*L-1:0] exp_q[$];
  int cyc_q[$];
  logic [3:0] ptab[16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  sti_sbox_pipe #(.LANES(L), .REMASK(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sh(in_sh),
    .rnd(rnd), .out_valid(out_valid), .out_ready(out_ready), .out_sh(out_sh), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4*L-1:0] collapse(logic [12*L-1:0] sh);
    logic [4*L-1:0] r;
    for (int l = 0; l < L; l++) r[4*l +: 4] = sh[12*l +: 4] ^ sh[12*l+4 +: 4] ^ sh[12*l+8 +: 4];
    return r;
  endfunction

  function automatic logic [4*L-1:0] present_ref(logic [4*L-1:0] x);
    logic [4*L-1:0] r;
    for (int l = 0; l < L; l++) r[4*l +: 4] = ptab[x[4*l +: 4]];
    return r;
  endfunction

  task automatic chk(string tag, logic [191:0] obs, logic [191:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 6; i++) in_sh[32*i +: 32] = $urandom();
    for (int i = 0; i < 4; i++) rnd[32*i +: 32] = $urandom();
  endtask

  // one clock: observe handshakes just before the edge, score them, then move to the next falling edge
  task automatic step();
    logic [4*L-1:0] e;
    int a;
    #1;
    acc  = in_valid & in_ready;
    emit = out_valid & out_ready;
    if (emit) begin
      last_out = out_sh;
      if (exp_q.size() == 0) chk("spurious_out", {191'b0, out_valid}, 192'd0);
      else begin
        e = exp_q.pop_front();
        a = cyc_q.pop_front();
        chk("data", collapse(out_sh), e);
        if (lat_chk) chk("latency", cyc - a, 2);
      end
    end
    if (acc) begin
      exp_q.push_back(present_ref(collapse(in_sh)));
      cyc_q.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic one(input logic [12*L-1:0] sh, input logic [8*L-1:0] r, output logic [12*L-1:0] o);
    logic got;
    in_sh = sh; rnd = r; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      step();
      got = emit;
    end
    chk("one_timeout", got, 1);
    o = last_out;
  endtask

  initial begin
    logic [12*L-1:0] snap, oa, ob, sh;
    int nacc, nemit;
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sh", out_sh, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    lat_chk = 1'b1; out_ready = 1'b1; in_valid = 1'b1; rnd = '0;
    for (int x = 0; x < 16; x++) begin
      for (int l = 0; l < L; l++) in_sh[12*l +: 12] = {8'h00, 4'(x)};
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("sweep_drain", exp_q.size(), 0);
    lat_chk = 1'b0;

    in_valid = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      randomize_inputs();
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("random_drain", exp_q.size(), 0);

    for (int k = 0; k < 4; k++) begin
      randomize_inputs();
      sh = in_sh;
      one(sh, rnd, oa);
      randomize_inputs();
      one(sh, rnd, ob);
      chk("remask_diff", oa !== ob, 1);
    end

    out_ready = 1'b0; in_valid = 1'b1; nacc = 0;
    randomize_inputs();
    for (int i = 0; i < 6; i++) begin
      if (i == 2) snap = out_sh;
      if (i > 2) chk("stall_hold", out_sh, snap);
      step();
      if (acc) begin nacc++; randomize_inputs(); end
    end
    chk("bp_accepts", nacc, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1'b1; nemit = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (acc) begin nacc++; in_valid = 1'b0; end
      if (emit) nemit++;
    end
    chk("bp_total_acc", nacc, 3);
    chk("bp_total_emit", nemit, 3);
    chk("bp_drain", exp_q.size(), 0);

    lat_chk = 1'b1; in_valid = 1'b1; out_ready = 1'b1; nacc = 0;
    for (int i = 0; i < 32; i++) begin
      randomize_inputs();
      step();
      if (acc) nacc++;
      if (i >= 2) chk("simul_adv", {acc, emit}, 2'b11);
    end
    chk("thru_accepts", nacc, 32);
    in_valid = 1'b0;
    repeat (3) step();
    chk("thru_drain", exp_q.size(), 0);
    lat_chk = 1'b0;

    out_ready = 1'b0; in_valid = 1'b1;
    randomize_inputs(); step();
    randomize_inputs(); step();
    in_valid = 1'b0;
    chk("mid_busy", busy, 1);
    chk("mid_full", out_valid, 1);
    rst = 1'b1;
    step();
    exp_q.delete();
    cyc_q.delete();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("no_stale", out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
